bus_slave_window: RTL and testbench

- Parametrised 8088-style minimum-mode bus slave sitting on the Peripheral side of the Intel8088Pins bus.
- Latches the multiplexed address on ALE and decodes a power-of-two address window in I/O or memory space.
- Inserts a programmable number of wait states via READY.
- Serves reads from, and captures writes into, an internal byte register file of DEPTH entries.

---
 rtl/bus_slave_window_if.sv | 52 +++++
 rtl/bus_slave_window.sv | 194 +++++++++++++++++++
 tb/tb_bus_slave_window.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_window_if.sv
// -----------------------------------------------------------------------------
// bus_slave_window_if
//
// Peripheral-side view of an 8088 minimum-mode bus, as seen by a single
// windowed slave. The AD bus tristate lives outside the slave, so the
// multiplexed lines are split into a sampled input (AD_IN) and a driven output
// (AD_OUT) qualified by OE.
//
// Signals:
//   ALE     address latch enable, active high
//   IOM     1 = I/O cycle, 0 = memory cycle
//   RD      read strobe, active low
//   WR      write strobe, active low
//   DEN     data enable, active low
//   A       upper address bits A[ADDR_W-1:8]
//   AD_IN   sampled value of AD[7:0]
//   AD_OUT  read data presented by the slave
//   OE      drive enable for AD_OUT
//   READY   0 = insert wait state
//   HIT     latched window match for the current bus cycle
//   ERR     sticky strobe-timeout flag
//
// Modports:
//   master  bus side (CPU / bench) driving ALE, strobes and address/data
//   slave   the windowed peripheral
// -----------------------------------------------------------------------------
interface bus_slave_window_if #(
  parameter int ADDR_W = 20
);
  logic              ALE;
  logic              IOM;
  logic              RD;
  logic              WR;
  logic              DEN;
  logic [ADDR_W-9:0] A;
  logic [7:0]        AD_IN;
  logic [7:0]        AD_OUT;
  logic              OE;
  logic              READY;
  logic              HIT;
  logic              ERR;

  modport master (
    output ALE, IOM, RD, WR, DEN, A, AD_IN,
    input  AD_OUT, OE, READY, HIT, ERR
  );

  modport slave (
    input  ALE, IOM, RD, WR, DEN, A, AD_IN,
    output AD_OUT, OE, READY, HIT, ERR
  );
endinterface

// File: rtl/bus_slave_window.sv
// -----------------------------------------------------------------------------
// bus_slave_window
//
// 8088-style minimum-mode bus slave. Latches the multiplexed address on ALE,
// decodes a DEPTH-aligned power-of-two window in I/O or memory space, stretches
// each hit cycle by WAIT_STATES cycles of READY=0 and then serves reads from /
// captures writes into an internal byte register file of DEPTH entries.
//
// Ports:
//   CLK    bus clock, rising edge
//   RESET  asynchronous, active-low reset
//   bus    bus_slave_window_if.slave (ALE, IOM, RD, WR, DEN, A, AD_IN in;
//          AD_OUT, OE, READY, HIT, ERR out)
//
// Optional feature macro: BUS_TIMEOUT_EN
//   Defined:   a strobe-stuck counter runs in SEL and ACCESS; after TIMEOUT
//              consecutive cycles there the cycle is dropped back to IDLE and
//              ERR is set (sticky until reset).
//   Undefined: no counter, ERR is tied low, SEL/ACCESS wait indefinitely.
// -----------------------------------------------------------------------------
module bus_slave_window #(
  parameter int               ADDR_W      = 20,
  parameter int               DEPTH       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(20'h00300),
  parameter bit               IS_IO       = 1'b1,
  parameter int               WAIT_STATES = 2,
  parameter int               TIMEOUT     = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  bus_slave_window_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hit_q, hit_d;
  logic             rd_cyc_q, rd_cyc_d;   // 1 = current hit cycle is a read
  logic             wrote_q, wrote_d;     // write already committed this cycle
  logic [7:0]       ad_out_q, ad_out_d;
  logic             mem_we;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_in;

  assign addr_in = {bus.A, bus.AD_IN};

  // Upper address bits select the window; the low IDX_W bits pick the entry,
  // so BASE_ADDR+DEPTH already falls outside.
  function automatic logic window_hit(input logic [ADDR_W-1:0] addr,
                                      input logic              iom);
    return (addr[ADDR_W-1:IDX_W] == BASE_ADDR[ADDR_W-1:IDX_W]) && (iom == IS_IO);
  endfunction

`ifdef BUS_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    rd_cyc_d = rd_cyc_q;
    wrote_d  = wrote_q;
    ad_out_d = ad_out_q;
    mem_we   = 1'b0;

    if (bus.ALE) begin
      // ALE wins over every other transition: any cycle in flight is dropped
      // without a write. Only the in-window index is kept; the rest of the
      // address and IOM are fully consumed by the decode here.
      idx_d   = addr_in[IDX_W-1:0];
      hit_d   = window_hit(addr_in, bus.IOM);
      state_d = window_hit(addr_in, bus.IOM) ? ST_SEL : ST_IDLE;
      cnt_d   = '0;
      wrote_d = 1'b0;
    end else begin
      case (state_q)
        ST_SEL: begin
          // Exactly one strobe low starts the data phase; both low is illegal
          // and both high means the strobe has not arrived yet.
          if (bus.RD != bus.WR) begin
            rd_cyc_d = !bus.RD;
            wrote_d  = 1'b0;
            if (WAIT_STATES == 0) begin
              state_d = ST_ACCESS;
              if (!bus.RD) ad_out_d = mem_q[idx_q];
            end else begin
              state_d = ST_WAIT;
              cnt_d   = 4'(WAIT_STATES);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
            if (rd_cyc_q) ad_out_d = mem_q[idx_q];
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_ACCESS: begin
          if (rd_cyc_q) begin
            if (bus.RD) state_d = ST_DONE;
          end else if (bus.WR) begin
            state_d = ST_DONE;
          end else if (!wrote_q) begin
            mem_we  = 1'b1;
            wrote_d = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end

`ifdef BUS_TIMEOUT_EN
    err_d  = err_q;
    tcnt_d = '0;
    // Count only while parked in SEL/ACCESS; any transition restarts the count.
    if (!bus.ALE && (state_q == ST_SEL || state_q == ST_ACCESS) && state_d == state_q) begin
      if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
        mem_we  = 1'b0;
      end else begin
        tcnt_d = tcnt_q + TCNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      rd_cyc_q <= 1'b0;
      wrote_q  <= 1'b0;
      ad_out_q <= '0;
`ifdef BUS_TIMEOUT_EN
      tcnt_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      rd_cyc_q <= rd_cyc_d;
      wrote_q  <= wrote_d;
      ad_out_q <= ad_out_d;
`ifdef BUS_TIMEOUT_EN
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Register file keeps its contents across reset; mem_we can only rise from
  // ACCESS, which reset leaves immediately.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[idx_q] <= bus.AD_IN;
  end

  assign bus.AD_OUT = ad_out_q;
  assign bus.READY  = (state_q != ST_WAIT);
  assign bus.OE     = (state_q == ST_ACCESS) && rd_cyc_q && !bus.RD && !bus.DEN;
  assign bus.HIT    = hit_q;
`ifdef BUS_TIMEOUT_EN
  assign bus.ERR    = err_q;
`else
  assign bus.ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_bus_slave_window.sv
`timescale 1ns/1ps
module tb_bus_slave_window;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ale, ale0, rd, rd0, wr, wr0, den, den0, iom;
  logic [11:0] a;
  logic [7:0]  ad;

  bus_slave_window_if #(.ADDR_W(20)) bus  ();
  bus_slave_window_if #(.ADDR_W(20)) bus0 ();

  assign bus.ALE   = ale;   assign bus.IOM   = iom;  assign bus.RD  = rd;
  assign bus.WR    = wr;    assign bus.DEN   = den;  assign bus.A   = a;
  assign bus.AD_IN = ad;
  assign bus0.ALE  = ale0;  assign bus0.IOM  = iom;  assign bus0.RD = rd0;
  assign bus0.WR   = wr0;   assign bus0.DEN  = den0; assign bus0.A  = a;
  assign bus0.AD_IN = ad;

  bus_slave_window #(.ADDR_W(20), .DEPTH(16), .BASE_ADDR(20'h00300), .IS_IO(1'b1),
                     .WAIT_STATES(2), .TIMEOUT(8))
    dut (.CLK(clk), .RESET(rst_n), .bus(bus.slave));

  bus_slave_window #(.ADDR_W(20), .DEPTH(16), .BASE_ADDR(20'h00300), .IS_IO(1'b1),
                     .WAIT_STATES(0), .TIMEOUT(8))
    dut0 (.CLK(clk), .RESET(rst_n), .bus(bus0.slave));

  int checks = 0;
  int errors = 0;
  int low0   = 0;

  bit         q_hit[$];
  bit         q_hit0[$];
  int         q_wait[$];
  logic [7:0] q_read[$];
  logic [7:0] q_read0[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples 3 ns after each rising edge and pops expectations as the
  // DUTs present HIT (after ALE), end of a READY-low run, and OE rising.
  initial begin : monitor
    int         run;
    logic       prev_oe, prev_oe0;
    logic [7:0] cur, cur0;
    run = 0; prev_oe = 1'b0; prev_oe0 = 1'b0; cur = '0; cur0 = '0;
    forever begin
      @(posedge clk); #3;
      if (ale) begin
        if (q_hit.size() == 0) chk("hit_unexpected", 1, 0);
        else chk("hit", bus.HIT, q_hit.pop_front());
      end
      if (!bus.READY) run++;
      else if (run != 0) begin
        if (q_wait.size() == 0) chk("wait_unexpected", run, 0);
        else chk("wait_len", run, q_wait.pop_front());
        run = 0;
      end
      if (bus.OE && !prev_oe) begin
        if (q_read.size() == 0) chk("oe_unexpected", 1, 0);
        else begin cur = q_read.pop_front(); chk("rd_data", bus.AD_OUT, cur); end
      end else if (bus.OE) chk("rd_hold", bus.AD_OUT, cur);
      prev_oe = bus.OE;

      if (ale0) begin
        if (q_hit0.size() == 0) chk("hit0_unexpected", 1, 0);
        else chk("hit0", bus0.HIT, q_hit0.pop_front());
      end
      if (!bus0.READY) low0++;
      if (bus0.OE && !prev_oe0) begin
        if (q_read0.size() == 0) chk("oe0_unexpected", 1, 0);
        else begin cur0 = q_read0.pop_front(); chk("rd0_data", bus0.AD_OUT, cur0); end
      end
      prev_oe0 = bus0.OE;
    end
  end

  task automatic set_ctl(input bit tgt, input logic r, input logic w, input logic d);
    if (tgt) begin rd0 = r; wr0 = w; den0 = d; end
    else     begin rd  = r; wr  = w; den  = d; end
  endtask

  task automatic do_ale(input bit tgt, input logic [19:0] addr, input logic io, input bit exp_hit);
    @(negedge clk);
    a = addr[19:8]; ad = addr[7:0]; iom = io;
    if (tgt) begin ale0 = 1'b1; q_hit0.push_back(exp_hit); end
    else     begin ale  = 1'b1; q_hit.push_back(exp_hit);  end
    @(negedge clk);
    ale = 1'b0; ale0 = 1'b0;
  endtask

  task automatic wr_phase(input bit tgt, input logic [7:0] data, input int ws, input bit hit);
    ad = data;
    set_ctl(tgt, 1'b1, 1'b0, 1'b0);
    if (hit && ws > 0) q_wait.push_back(ws);
    repeat (ws + 2) @(negedge clk);
    set_ctl(tgt, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic rd_phase(input bit tgt, input logic [7:0] exp, input int ws, input bit hit);
    set_ctl(tgt, 1'b0, 1'b1, 1'b0);
    if (hit) begin
      if (ws > 0) q_wait.push_back(ws);
      if (tgt) q_read0.push_back(exp); else q_read.push_back(exp);
    end
    repeat (ws + 2) @(negedge clk);
    set_ctl(tgt, 1'b1, 1'b1, 1'b1);
    #1 chk("oe_release", tgt ? bus0.OE : bus.OE, 0);
    @(posedge clk); #1 chk("oe_done", tgt ? bus0.OE : bus.OE, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ale = 1'b0; ale0 = 1'b0; rd = 1'b1; rd0 = 1'b1; wr = 1'b1; wr0 = 1'b1;
    den = 1'b1; den0 = 1'b1; iom = 1'b0; a = '0; ad = '0;
    #7;
    chk("rst_adout", bus.AD_OUT, 0);
    chk("rst_oe",    bus.OE,     0);
    chk("rst_ready", bus.READY,  1);
    chk("rst_hit",   bus.HIT,    0);
    chk("rst_err",   bus.ERR,    0);
    chk("rst_ready0", bus0.READY, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read back through the default 2-wait-state slave.
    do_ale(0, 20'h00305, 1'b1, 1'b1); wr_phase(0, 8'hA5, 2, 1'b1);
    do_ale(0, 20'h00305, 1'b1, 1'b1); rd_phase(0, 8'hA5, 2, 1'b1);
    chk("hit_hold_idle", bus.HIT, 1);

    // Misses: one past the window, and the right address in memory space.
    do_ale(0, 20'h00300, 1'b1, 1'b1); wr_phase(0, 8'h66, 2, 1'b1);
    do_ale(0, 20'h00310, 1'b1, 1'b0); wr_phase(0, 8'h00, 2, 1'b0);
    do_ale(0, 20'h00305, 1'b0, 1'b0); wr_phase(0, 8'h00, 2, 1'b0);
    do_ale(0, 20'h00305, 1'b1, 1'b1); rd_phase(0, 8'hA5, 2, 1'b1);
    do_ale(0, 20'h00300, 1'b1, 1'b1); rd_phase(0, 8'h66, 2, 1'b1);
    do_ale(0, 20'h002FF, 1'b1, 1'b0); rd_phase(0, 8'h00, 2, 1'b0);
    chk("miss_hit_idle", bus.HIT, 0);

    // Zero wait states.
    do_ale(1, 20'h00300, 1'b1, 1'b1); wr_phase(1, 8'h3C, 0, 1'b1);
    do_ale(1, 20'h00300, 1'b1, 1'b1); rd_phase(1, 8'h3C, 0, 1'b1);

    // Reset pulsed during the WAIT of a write.
    do_ale(0, 20'h0030A, 1'b1, 1'b1); wr_phase(0, 8'h11, 2, 1'b1);
    do_ale(0, 20'h0030A, 1'b1, 1'b1);
    ad = 8'h77; set_ctl(0, 1'b1, 1'b0, 1'b0); q_wait.push_back(1);
    @(posedge clk); #4 rst_n = 1'b0; #1;
    chk("abort_ready", bus.READY,  1);
    chk("abort_hit",   bus.HIT,    0);
    chk("abort_oe",    bus.OE,     0);
    chk("abort_adout", bus.AD_OUT, 0);
    set_ctl(0, 1'b1, 1'b1, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_ale(0, 20'h0030A, 1'b1, 1'b1); rd_phase(0, 8'h11, 2, 1'b1);

    // New ALE during WAIT restarts decode without writing.
    do_ale(0, 20'h0030B, 1'b1, 1'b1); wr_phase(0, 8'h22, 2, 1'b1);
    do_ale(0, 20'h0030B, 1'b1, 1'b1);
    ad = 8'h99; set_ctl(0, 1'b1, 1'b0, 1'b0); q_wait.push_back(1);
    @(negedge clk);
    set_ctl(0, 1'b1, 1'b1, 1'b1);
    a = 12'h003; ad = 8'h0B; iom = 1'b1; ale = 1'b1; q_hit.push_back(1'b1);
    @(negedge clk); ale = 1'b0;
    rd_phase(0, 8'h22, 2, 1'b1);

    // RD and WR low together: no action, stays selected.
    do_ale(0, 20'h00301, 1'b1, 1'b1); wr_phase(0, 8'h44, 2, 1'b1);
    do_ale(0, 20'h00301, 1'b1, 1'b1);
    ad = 8'hEE; set_ctl(0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("illegal_ready", bus.READY, 1);
      chk("illegal_oe",    bus.OE,    0);
    end
    set_ctl(0, 1'b1, 1'b1, 1'b1);
    rd_phase(0, 8'h44, 2, 1'b1);

`ifdef BUS_TIMEOUT_EN
    do_ale(0, 20'h00302, 1'b1, 1'b1);
    repeat (7) @(negedge clk);
    chk("err_before", bus.ERR, 0);
    @(negedge clk);
    chk("err_set", bus.ERR, 1);
    chk("err_ready", bus.READY, 1);
    do_ale(0, 20'h00302, 1'b1, 1'b1); wr_phase(0, 8'h81, 2, 1'b1);
    do_ale(0, 20'h00302, 1'b1, 1'b1); rd_phase(0, 8'h81, 2, 1'b1);
    chk("err_sticky", bus.ERR, 1);
`else
    do_ale(0, 20'h00302, 1'b1, 1'b1);
    repeat (12) @(negedge clk);
    chk("err_zero", bus.ERR, 0);
    chk("sel_ready", bus.READY, 1);
    wr_phase(0, 8'h81, 2, 1'b1);
    do_ale(0, 20'h00302, 1'b1, 1'b1); rd_phase(0, 8'h81, 2, 1'b1);
    chk("err_zero_end", bus.ERR, 0);
`endif

    repeat (3) @(negedge clk);
    chk("ws0_ready_low", low0, 0);
    chk("q_hit_left",   q_hit.size(),   0);
    chk("q_hit0_left",  q_hit0.size(),  0);
    chk("q_wait_left",  q_wait.size(),  0);
    chk("q_read_left",  q_read.size(),  0);
    chk("q_read0_left", q_read0.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
